pong_ball: RTL

//  Ball engine, downstream of the paddle stage. Consumes both paddle geometries, advances the ball once per frame_clk edge,

---
 rtl/pong_pkg.sv | 53 +++++
 rtl/pong_collide.sv | 62 ++++++
 rtl/pong_ball.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong ball engine and its paddle stage.
// Optional feature macro: PONG_SPIN_EN (paddle hit zone steers the ball's Y motion).
package pong_pkg;

    localparam int COORD_W     = 10;
    localparam int SCORE_W     = 4;

    localparam int BALL_S      = 4;
    localparam int X_CENTER    = 320;
    localparam int Y_CENTER    = 240;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 639;
    localparam int Y_MIN       = 20;
    localparam int Y_MAX       = 461;
    localparam int STEP        = 2;
    localparam int SERVE_DELAY = 60;
    localparam int SCORE_MAX   = 7;

    localparam int SERVE_CNT_W = $clog2(SERVE_DELAY);

    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} ball_state_t;

    // Per-axis motion, 10-bit two's complement, one of {-STEP, 0, +STEP}
    typedef logic signed [COORD_W-1:0] motion_t;

    localparam motion_t MOT_POS  = motion_t'(STEP);
    localparam motion_t MOT_NEG  = motion_t'(-STEP);
    localparam motion_t MOT_ZERO = '0;

    // Where on the paddle the ball landed; HIGH is above centre (smaller Y)
    typedef enum logic [1:0] {ZONE_FLAT, ZONE_HIGH, ZONE_LOW} hit_zone_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] l;
        logic [COORD_W-1:0] w;
    } paddle_t;

    // Scores stop at SCORE_MAX rather than wrapping
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
    endfunction

    function automatic motion_t zone_motion(input hit_zone_t z);
        case (z)
            ZONE_HIGH: return MOT_NEG;
            ZONE_LOW:  return MOT_POS;
            default:   return MOT_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/pong_collide.sv
// Combinational ball-vs-paddle hit test for one paddle.
// RIGHT=0 tests the left paddle (ball travelling left), RIGHT=1 the right one.
// Optional feature macro: PONG_SPIN_EN adds the hit-zone output.
module pong_collide
    import pong_pkg::*;
#(
    parameter bit RIGHT = 1'b0
)(
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  paddle_t            pad,
    input  motion_t            x_mot,
    output logic               hit
`ifdef PONG_SPIN_EN
    ,
    output hit_zone_t          zone
`endif
);

    // Two guard bits so paddle-minus-extent never wraps near the screen edge
    localparam int EXT_W = COORD_W + 2;

    logic signed [EXT_W-1:0] bx, by, px, py, pl, pw, bs;
    logic signed [EXT_W-1:0] x_lo, x_hi, y_lo, y_hi;
    logic                    dir_ok;

    assign bx = $signed({2'b00, ball_x});
    assign by = $signed({2'b00, ball_y});
    assign px = $signed({2'b00, pad.x});
    assign py = $signed({2'b00, pad.y});
    assign pl = $signed({2'b00, pad.l});
    assign pw = $signed({2'b00, pad.w});
    assign bs = EXT_W'(BALL_S);

    // Contact window: ball edge touching the paddle face it is moving toward
    always_comb begin
        x_lo   = RIGHT ? (px - pw - bs) : (px - pw + bs);
        x_hi   = RIGHT ? (px + pw - bs) : (px + pw + bs);
        y_lo   = py - pl - bs;
        y_hi   = py + pl + bs;
        dir_ok = RIGHT ? (!x_mot[COORD_W-1] && (x_mot != MOT_ZERO)) : x_mot[COORD_W-1];
        hit    = dir_ok && (bx >= x_lo) && (bx <= x_hi) && (by >= y_lo) && (by <= y_hi);
    end

`ifdef PONG_SPIN_EN
    logic signed [EXT_W-1:0] offset, third;

    assign offset = by - py;
    assign third  = $signed({2'b00, pad.l / COORD_W'(3)});

    // Outer thirds of the paddle deflect, middle third returns flat
    always_comb begin
        if (offset < -third)
            zone = ZONE_HIGH;
        else if (offset > third)
            zone = ZONE_LOW;
        else
            zone = ZONE_FLAT;
    end
`endif

endmodule

// File: rtl/pong_ball.sv
// Ball engine: serve delay, per-frame motion, wall/paddle reflection, scoring.
// Optional feature macro: PONG_SPIN_EN (paddle hit zone sets the Y motion).
module pong_ball
    import pong_pkg::*;
(
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] Paddle1X,
    input  logic [COORD_W-1:0] Paddle1Y,
    input  logic [COORD_W-1:0] Paddle1L,
    input  logic [COORD_W-1:0] Paddle1W,
    input  logic [COORD_W-1:0] Paddle2X,
    input  logic [COORD_W-1:0] Paddle2Y,
    input  logic [COORD_W-1:0] Paddle2L,
    input  logic [COORD_W-1:0] Paddle2W,
    output logic [COORD_W-1:0] BallX,
    output logic [COORD_W-1:0] BallY,
    output logic [COORD_W-1:0] BallS,
    output logic [SCORE_W-1:0] Score1,
    output logic [SCORE_W-1:0] Score2,
    output logic               resetB,
    output logic               game_over
);

    localparam logic [COORD_W-1:0]     X_CTR    = COORD_W'(X_CENTER);
    localparam logic [COORD_W-1:0]     Y_CTR    = COORD_W'(Y_CENTER);
    localparam logic [COORD_W-1:0]     X_GOAL_L = COORD_W'(X_MIN + BALL_S);
    localparam logic [COORD_W-1:0]     X_GOAL_R = COORD_W'(X_MAX - BALL_S);
    localparam logic [COORD_W-1:0]     Y_WALL_T = COORD_W'(Y_MIN + BALL_S);
    localparam logic [COORD_W-1:0]     Y_WALL_B = COORD_W'(Y_MAX - BALL_S);
    localparam logic [SCORE_W-1:0]     S_MAX    = SCORE_W'(SCORE_MAX);
    localparam logic [SERVE_CNT_W-1:0] CNT_LAST = SERVE_CNT_W'(SERVE_DELAY - 1);

    ball_state_t              state, state_n;
    logic [COORD_W-1:0]       ball_x, ball_y, bx_n, by_n;
    motion_t                  x_mot, y_mot, xm_n, ym_n;
    logic [SCORE_W-1:0]       score1, score2, s1_n, s2_n;
    logic                     serve_right, serve_r_n;
    logic [SERVE_CNT_W-1:0]   serve_cnt, cnt_n;
    logic                     reset_b, rb_n;
    logic                     goal;

    paddle_t [1:0]            pad;
    logic    [1:0]            hit;
`ifdef PONG_SPIN_EN
    hit_zone_t [1:0]          zone;
`endif

    assign pad[0] = '{x: Paddle1X, y: Paddle1Y, l: Paddle1L, w: Paddle1W};
    assign pad[1] = '{x: Paddle2X, y: Paddle2Y, l: Paddle2L, w: Paddle2W};

    // Index 0 is the left paddle, index 1 the right one
    for (genvar p = 0; p < 2; p++) begin : g_col
        pong_collide #(
            .RIGHT (p == 1)
        ) u_col (
            .ball_x (ball_x),
            .ball_y (ball_y),
            .pad    (pad[p]),
            .x_mot  (x_mot),
            .hit    (hit[p])
`ifdef PONG_SPIN_EN
            ,
            .zone   (zone[p])
`endif
        );
    end

    // State register and all per-frame ball/score state
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state       <= SERVE;
            ball_x      <= X_CTR;
            ball_y      <= Y_CTR;
            x_mot       <= MOT_ZERO;
            y_mot       <= MOT_ZERO;
            score1      <= '0;
            score2      <= '0;
            serve_right <= 1'b0;
            serve_cnt   <= '0;
            reset_b     <= 1'b0;
        end else begin
            state       <= state_n;
            ball_x      <= bx_n;
            ball_y      <= by_n;
            x_mot       <= xm_n;
            y_mot       <= ym_n;
            score1      <= s1_n;
            score2      <= s2_n;
            serve_right <= serve_r_n;
            serve_cnt   <= cnt_n;
            reset_b     <= rb_n;
        end
    end

    // Next-state: motion decided this frame is applied to position this frame
    always_comb begin
        state_n   = state;
        bx_n      = ball_x;
        by_n      = ball_y;
        xm_n      = x_mot;
        ym_n      = y_mot;
        s1_n      = score1;
        s2_n      = score2;
        serve_r_n = serve_right;
        cnt_n     = serve_cnt;
        rb_n      = 1'b0;
        goal      = 1'b0;

        case (state)
            SERVE: begin
                xm_n = MOT_ZERO;
                ym_n = MOT_ZERO;
                if (serve_cnt == CNT_LAST) begin
                    xm_n    = serve_right ? MOT_POS : MOT_NEG;
                    ym_n    = MOT_POS;
                    cnt_n   = '0;
                    state_n = PLAY;
                end else begin
                    cnt_n = serve_cnt + SERVE_CNT_W'(1);
                end
                bx_n = ball_x + xm_n;
                by_n = ball_y + ym_n;
            end

            PLAY: begin
                // Paddle contact outranks the goal line in the same frame
                if (hit[0]) begin
                    xm_n = MOT_POS;
`ifdef PONG_SPIN_EN
                    ym_n = zone_motion(zone[0]);
`endif
                end else if (hit[1]) begin
                    xm_n = MOT_NEG;
`ifdef PONG_SPIN_EN
                    ym_n = zone_motion(zone[1]);
`endif
                end else if (ball_x <= X_GOAL_L) begin
                    goal      = 1'b1;
                    s2_n      = score_inc(score2);
                    serve_r_n = 1'b0;
                end else if (ball_x >= X_GOAL_R) begin
                    goal      = 1'b1;
                    s1_n      = score_inc(score1);
                    serve_r_n = 1'b1;
                end

                // Walls act on the incoming direction and win over spin
                if (ball_y <= Y_WALL_T && y_mot[COORD_W-1])
                    ym_n = MOT_POS;
                else if (ball_y >= Y_WALL_B && !y_mot[COORD_W-1] && y_mot != MOT_ZERO)
                    ym_n = MOT_NEG;

                if (goal) begin
                    state_n = POINT;
                    rb_n    = 1'b1;
                    bx_n    = X_CTR;
                    by_n    = Y_CTR;
                    xm_n    = MOT_ZERO;
                    ym_n    = MOT_ZERO;
                end else begin
                    bx_n = ball_x + xm_n;
                    by_n = ball_y + ym_n;
                end
            end

            POINT: begin
                bx_n  = X_CTR;
                by_n  = Y_CTR;
                xm_n  = MOT_ZERO;
                ym_n  = MOT_ZERO;
                cnt_n = '0;
                if (score1 == S_MAX || score2 == S_MAX)
                    state_n = OVER;
                else
                    state_n = SERVE;
            end

            OVER: begin
                bx_n = X_CTR;
                by_n = Y_CTR;
                xm_n = MOT_ZERO;
                ym_n = MOT_ZERO;
            end

            default: state_n = SERVE;
        endcase
    end

    assign BallX     = ball_x;
    assign BallY     = ball_y;
    assign BallS     = COORD_W'(BALL_S);
    assign Score1    = score1;
    assign Score2    = score2;
    assign resetB    = reset_b;
    assign game_over = (state == OVER);

endmodule
